// File: rtl/stc_framer_param_if.sv
// Framer data/status bundle; master = upstream driver side, slave = framer side.
interface stc_framer_param_if;
    logic        clkEn;
    logic        stcMode;
    logic        payloadBit;
    logic        payloadBitEn;
    logic        stcBit0;
    logic        stcBit1;
    logic        pilotActive;
    logic        frameStart;
    logic [15:0] frameCount;

    modport master (
        output clkEn, stcMode, payloadBit,
        input  payloadBitEn, stcBit0, stcBit1, pilotActive, frameStart, frameCount
    );

    modport slave (
        input  clkEn, stcMode, payloadBit,
        output payloadBitEn, stcBit0, stcBit1, pilotActive, frameStart, frameCount
    );
endinterface

// File: rtl/stc_framer_param.sv
// Alamouti STC framer: pilot + 4-bit-block payload frames, one registered symbol per clkEn edge.
// Upstream is pulled via payloadBitEn; nothing moves or samples while clkEn is low.
module stc_framer_param #(
    parameter int           PAYLOAD_BITS = 3200,
    parameter int           PILOT_BITS   = 128,
    parameter logic [127:0] PILOT0       = 128'ha88d_9ad4_dc40_4947_e292_023b_2b59_b115,
    parameter logic [127:0] PILOT1       = 128'he3c7_7761_f070_36be_7d6c_0e0f_86ee_e3c7,
    parameter int           CNT_W        = 12
) (
    input  logic              clk,
    input  logic              reset,
    stc_framer_param_if.slave bus
);
    localparam logic [CNT_W-1:0] PIL_LAST  = CNT_W'(PILOT_BITS - 1);
    localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAYLOAD_BITS - 1);
    localparam logic [CNT_W-1:0] FETCH_ON  = CNT_W'(PILOT_BITS - 4);
    localparam logic [CNT_W-1:0] FETCH_OFF = CNT_W'(PAYLOAD_BITS - 4);

    typedef enum logic [1:0] {IDLE = 2'd0, PILOT = 2'd1, PAYLOAD = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [2:0]       sr_q, sr_d;
    logic [3:0]       blk_q, blk_d;
    logic             en_q, en_d;
    logic             s0_q, s0_d, s1_q, s1_d;
    logic             pa_q, pa_d, fs_q, fs_d;
    logic [15:0]      fc_q, fc_d;

    logic [6:0]       pidx;
    logic [3:0]       cur_blk;
    logic             b0, b1, b2, b3;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            sr_q    <= '0;
            blk_q   <= '0;
            en_q    <= 1'b0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            pa_q    <= 1'b0;
            fs_q    <= 1'b0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            sr_q    <= sr_d;
            blk_q   <= blk_d;
            en_q    <= en_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            pa_q    <= pa_d;
            fs_q    <= fs_d;
            fc_q    <= fc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.clkEn) begin
            unique case (state_q)
                IDLE: begin
                    state_d = PILOT;
                    cnt_d   = '0;
                end
                PILOT: begin
                    if (cnt_q == PIL_LAST) begin
                        state_d = PAYLOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (cnt_q == PAY_LAST) begin
                        state_d = PILOT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // At a block's first symbol the fourth bit is being sampled on this same edge,
    // so the block is assembled from the three held bits plus the live input.
    always_comb begin
        sr_d    = sr_q;
        blk_d   = blk_q;
        en_d    = en_q;
        mode_d  = mode_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        pa_d    = pa_q;
        fs_d    = fs_q;
        fc_d    = fc_q;
        pidx    = 7'd127 - 7'(cnt_d);
        cur_blk = (cnt_d[1:0] == 2'd0) ? {sr_q, bus.payloadBit} : blk_q;
        {b0, b1, b2, b3} = cur_blk;
        if (bus.clkEn) begin
            if (en_q) begin
                sr_d = {sr_q[1:0], bus.payloadBit};
            end
            en_d = ((state_d == PILOT) && (cnt_d >= FETCH_ON)) ||
                   ((state_d == PAYLOAD) && (cnt_d < FETCH_OFF));
            pa_d = 1'b0;
            fs_d = 1'b0;
            unique case (state_d)
                PILOT: begin
                    s0_d = PILOT0[pidx];
                    s1_d = PILOT1[pidx];
                    pa_d = 1'b1;
                    fs_d = (cnt_d == '0);
                    if (state_q != PILOT) begin
                        mode_d = bus.stcMode;
                        fc_d   = (state_q == IDLE) ? 16'd0 : fc_q + 16'd1;
                    end
                end
                PAYLOAD: begin
                    blk_d = cur_blk;
                    unique case (cnt_d[1:0])
                        2'd0: begin s0_d = b0; s1_d = mode_q ? b0 : b2; end
                        2'd1: begin s0_d = b1; s1_d = mode_q ? b1 : b3; end
                        2'd2: begin s0_d = mode_q ? b2 : ~b2; s1_d = mode_q ? b2 : b0; end
                        default: begin s0_d = b3; s1_d = mode_q ? b3 : ~b1; end
                    endcase
                end
                default: begin
                    s0_d = 1'b0;
                    s1_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.payloadBitEn = en_q;
    assign bus.stcBit0      = s0_q;
    assign bus.stcBit1      = s1_q;
    assign bus.pilotActive  = pa_q;
    assign bus.frameStart   = fs_q;
    assign bus.frameCount   = fc_q;
endmodule

// File: tb/tb_stc_framer_param.sv
// Scoreboarded bench: small-frame instance checked symbol by symbol, default instance checked per frame.
module tb_stc_framer_param;
    localparam int PB = 8;
    localparam int PL = 16;
    localparam int FL = PB + PL;
    localparam logic [127:0] P0 = 128'ha88d_9ad4_dc40_4947_e292_023b_2b59_b115;
    localparam logic [127:0] P1 = 128'he3c7_7761_f070_36be_7d6c_0e0f_86ee_e3c7;

    typedef struct packed {
        logic        s0;
        logic        s1;
        logic        pa;
        logic        fs;
        logic        en;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;
    always #5 clk = ~clk;

    stc_framer_param_if bus ();
    stc_framer_param_if bus2 ();

    stc_framer_param #(.PAYLOAD_BITS(PL), .PILOT_BITS(PB)) dut (
        .clk(clk), .reset(rst_n), .bus(bus)
    );
    stc_framer_param dut2 (
        .clk(clk), .reset(rst2_n), .bus(bus2)
    );

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    logic data_q[$];
    logic mode_plan[8];
    int   k;
    int   rnd_from;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected symbols for one frame plus the 16 payload bits it will consume (MSB first).
    task automatic push_frame(input logic [15:0] fc, input logic mode, input logic [15:0] data);
        exp_t        e;
        logic [127:0] p0v;
        logic [127:0] p1v;
        logic [3:0]  blk, stc0, stc1, unc;
        int          s;
        p0v = P0;
        p1v = P1;
        for (int pos = 0; pos < PB; pos++) begin
            e.s0 = p0v[127-pos];
            e.s1 = p1v[127-pos];
            e.pa = 1'b1;
            e.fs = (pos == 0);
            e.en = (pos >= PB - 4);
            e.fc = fc;
            exp_q.push_back(e);
        end
        for (int j = 0; j < PL; j++) begin
            blk  = data[15 - 4*(j/4) -: 4];
            stc0 = {blk[3], blk[2], ~blk[1], blk[0]};
            stc1 = {blk[1], blk[0], blk[3], ~blk[2]};
            unc  = blk;
            s    = j % 4;
            e.s0 = mode ? unc[3-s] : stc0[3-s];
            e.s1 = mode ? unc[3-s] : stc1[3-s];
            e.pa = 1'b0;
            e.fs = 1'b0;
            e.en = (j < PL - 4);
            e.fc = fc;
            exp_q.push_back(e);
        end
        for (int i = 15; i >= 0; i--) data_q.push_back(data[i]);
    endtask

    // Issue clkEn edges until k reaches target; stcMode is flipped late in every frame.
    task automatic run_to(input int target, input int budget);
        int   n;
        int   pos;
        int   f;
        logic ce;
        n = 0;
        while (k < target && n < budget) begin
            @(negedge clk);
            n++;
            ce = (k >= rnd_from) ? ($urandom_range(0, 99) < 30) : 1'b1;
            if (ce) begin
                pos = k % FL;
                f   = k / FL;
                if (pos == 0) bus.stcMode = mode_plan[f];
                else if (pos >= PB + 5) bus.stcMode = ~mode_plan[f];
                if (bus.payloadBitEn) begin
                    if (data_q.size() > 0) begin
                        bus.payloadBit = data_q.pop_front();
                    end else begin
                        chk("data_underflow", 128'(data_q.size()), 128'd1);
                        bus.payloadBit = 1'b0;
                    end
                end else begin
                    bus.payloadBit = 1'($urandom_range(0, 1));
                end
                k++;
            end else begin
                bus.stcMode    = 1'($urandom_range(0, 1));
                bus.payloadBit = 1'($urandom_range(0, 1));
            end
            bus.clkEn = ce;
        end
        if (k < target) chk("drive_timeout", 128'(k), 128'(target));
    endtask

    // Main scoreboard monitor.
    logic m_ce, m_rst, m_en;
    exp_t obs, e_pop, last_exp;
    int   consumed;
    bit   fs_seen;
    always @(posedge clk) begin
        m_ce  = bus.clkEn;
        m_rst = rst_n;
        m_en  = bus.payloadBitEn;
        #1;
        obs = {bus.stcBit0, bus.stcBit1, bus.pilotActive, bus.frameStart,
               bus.payloadBitEn, bus.frameCount};
        if (!m_rst) begin
            chk("reset_outputs_zero", 128'(obs), 128'd0);
            consumed = 0;
            fs_seen  = 1'b0;
            last_exp = '0;
        end else if (m_ce) begin
            if (bus.frameStart) begin
                if (fs_seen) chk("bits_per_frame", 128'(consumed), 128'(PL));
                fs_seen  = 1'b1;
                consumed = 0;
            end
            if (m_en) consumed++;
            if (exp_q.size() == 0) begin
                chk("expected_symbol_available", 128'(exp_q.size() != 0), 128'd1);
            end else begin
                e_pop = exp_q.pop_front();
                chk("symbol", 128'(obs), 128'(e_pop));
                last_exp = e_pop;
            end
        end else begin
            chk("hold_without_clken", 128'(obs), 128'(last_exp));
        end
    end

    // Default-parameter instance: per-frame structure, consumption and pilot content.
    int           f2 = -1;
    bit           done2 = 1'b0;
    int           pil_cnt, pay_cnt, cons2;
    logic [127:0] pw0, pw1;
    logic         m2_en, m2_rst;
    always @(posedge clk) begin
        m2_en  = bus2.payloadBitEn;
        m2_rst = rst2_n;
        #1;
        if (m2_rst && !done2) begin
            if (bus2.frameStart) begin
                if (f2 >= 0) begin
                    chk("dflt_pilot_syms", 128'(pil_cnt), 128'd128);
                    chk("dflt_payload_syms", 128'(pay_cnt), 128'd3200);
                    chk("dflt_bits_consumed", 128'(cons2), 128'd3200);
                    chk("dflt_pilot0", pw0, P0);
                    chk("dflt_pilot1", pw1, P1);
                end
                f2++;
                if (f2 == 3) done2 = 1'b1;
                else chk("dflt_frame_count", 128'(bus2.frameCount), 128'(f2));
                pil_cnt = 0;
                pay_cnt = 0;
                cons2   = 0;
            end
            if (bus2.pilotActive) begin
                pil_cnt++;
                pw0 = {pw0[126:0], bus2.stcBit0};
                pw1 = {pw1[126:0], bus2.stcBit1};
            end else begin
                pay_cnt++;
            end
            if (m2_en) cons2++;
        end
    end

    initial begin
        bus2.clkEn      = 1'b0;
        bus2.stcMode    = 1'b0;
        bus2.payloadBit = 1'b0;
        rst2_n          = 1'b0;
        repeat (2) @(negedge clk);
        rst2_n     = 1'b1;
        bus2.clkEn = 1'b1;
        forever begin
            @(negedge clk);
            bus2.payloadBit = 1'($urandom_range(0, 1));
            bus2.stcMode    = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int n;
        bus.clkEn      = 1'b0;
        bus.stcMode    = 1'b0;
        bus.payloadBit = 1'b0;
        rst_n          = 1'b0;
        k              = 0;
        rnd_from       = 1 << 30;
        repeat (3) @(negedge clk);

        // Frames 0-2 at full rate, 3-4 with ~30% clkEn duty; STC/uncoded alternate.
        mode_plan = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        push_frame(16'd0, 1'b0, 16'b1000_0111_1010_0011);
        push_frame(16'd1, 1'b1, 16'b1101_0110_1001_1111);
        push_frame(16'd2, 1'b0, 16'h5c3e);
        push_frame(16'd3, 1'b1, 16'h96a1);
        push_frame(16'd4, 1'b0, 16'h3f08);
        rst_n = 1'b1;
        run_to(3 * FL, 200);
        rnd_from = 3 * FL;
        run_to(5 * FL, 3000);
        @(negedge clk) bus.clkEn = 1'b0;
        repeat (2) @(negedge clk);

        // Abort frame 5 inside payload block 2, then restart from frame 0.
        rnd_from = 1 << 30;
        push_frame(16'd5, 1'b0, 16'h7e81);
        run_to(5 * FL + PB + 10, 200);
        @(negedge clk);
        rst_n     = 1'b0;
        bus.clkEn = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.delete();
        data_q.delete();
        k         = 0;
        mode_plan = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        push_frame(16'd0, 1'b1, 16'hb4d2);
        push_frame(16'd1, 1'b0, 16'h1e6c);
        bus.clkEn = 1'b0;
        rst_n     = 1'b1;
        run_to(2 * FL, 200);
        @(negedge clk) bus.clkEn = 1'b0;
        repeat (4) @(negedge clk);
        chk("exp_queue_drained", 128'(exp_q.size()), 128'd0);
        chk("data_queue_drained", 128'(data_q.size()), 128'd0);

        n = 0;
        while (!done2 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!done2) chk("dflt_run_timeout", 128'(done2), 128'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
